axis_vector_peak_detect: RTL

//  Terminating receiver for RFNoC spectral vector streams (FFT -> vector IIR -> keep-one-in-N).

---
 rtl/axis_vector_peak_pkg.sv | 21 ++
 rtl/axis_vector_peak_detect_peak_track.sv | 72 +++++++
 rtl/axis_vector_peak_detect.sv | 135 +++++++++++++
 3 files changed

// File: rtl/axis_vector_peak_pkg.sv
// Shared types and default widths for the AXI-Stream vector peak detector.
package axis_vector_peak_pkg;

    localparam int MAG_W = 16;
    localparam int LEN_W = 16;
    localparam int SUM_W = 40;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        HOLD   = 2'd1,
        RESYNC = 2'd2
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] bin;
        logic [MAG_W-1:0] val;
        logic             len_err;
        logic [SUM_W-1:0] sum;
    } result_t;

endpackage

// File: rtl/axis_vector_peak_detect_peak_track.sv
// Running max/argmax (and magnitude sum when VECTOR_PEAK_SUM_EN is defined) over one vector.
// The next-state values are exported so the caller can capture the result on the final beat.
module peak_track #(
    parameter int MAG_WIDTH = 16,
    parameter int LEN_WIDTH = 16,
    parameter int SUM_WIDTH = 40
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 upd_i,
    input  logic [MAG_WIDTH-1:0] mag_i,
    input  logic [LEN_WIDTH-1:0] idx_i,
    output logic [MAG_WIDTH-1:0] nxt_val_o,
    output logic [LEN_WIDTH-1:0] nxt_idx_o,
    output logic [SUM_WIDTH-1:0] nxt_sum_o
);

    logic [MAG_WIDTH-1:0] val_q, val_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        val_d = val_q;
        idx_d = idx_q;
        if (clear_i) begin
            val_d = '0;
            idx_d = '0;
        end else if (load_i) begin
            val_d = mag_i;
            idx_d = idx_i;
        end else if (upd_i && (mag_i > val_q)) begin
            val_d = mag_i;
            idx_d = idx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign nxt_val_o = val_d;
    assign nxt_idx_o = idx_d;

`ifdef VECTOR_PEAK_SUM_EN
    logic [SUM_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i)     sum_d = '0;
        else if (load_i) sum_d = SUM_WIDTH'(mag_i);
        else if (upd_i)  sum_d = sum_q + SUM_WIDTH'(mag_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign nxt_sum_o = sum_d;
`else
    assign nxt_sum_o = '0;
`endif

endmodule

// File: rtl/axis_vector_peak_detect.sv
// Terminating AXI-Stream spectral vector receiver: peak bin/value per vector with framing checks.
// Optional energy sum on o_sum when VECTOR_PEAK_SUM_EN is defined (otherwise o_sum is 0).
module axis_vector_peak_detect
    import axis_vector_peak_pkg::*;
#(
    parameter int MAG_WIDTH = MAG_W,
    parameter int LEN_WIDTH = LEN_W,
    parameter int SUM_WIDTH = SUM_W
) (
    input  logic                 ce_clk,
    input  logic                 ce_rst_n,
    input  logic [31:0]          i_tdata,
    input  logic                 i_tlast,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    input  logic [LEN_WIDTH-1:0] vector_len,
    output logic [LEN_WIDTH-1:0] o_peak_bin,
    output logic [MAG_WIDTH-1:0] o_peak_val,
    output logic                 o_len_err,
    output logic [SUM_WIDTH-1:0] o_sum,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic                 err_early,
    output logic                 err_late
);

    state_t               state_q;
    logic [LEN_WIDTH-1:0] cnt_q, len_q;
    logic                 late_pend_q, tready_q, valid_q;
    logic                 err_early_q, err_late_q;
    result_t              res_q, res_d;

    logic [MAG_WIDTH-1:0] mag;
    logic                 unused_imag;
    logic [LEN_WIDTH-1:0] cur_len, last_idx;
    logic                 acc_beat, final_beat, early, late;
    logic [MAG_WIDTH-1:0] nxt_val;
    logic [LEN_WIDTH-1:0] nxt_idx;
    logic [SUM_WIDTH-1:0] nxt_sum;

    assign mag         = i_tdata[31 -: MAG_WIDTH];
    assign unused_imag = ^i_tdata[31-MAG_WIDTH:0];

    // Length is latched on beat 0, so beat 0 compares against the live port (0 means 1).
    assign cur_len    = (cnt_q == '0) ? ((vector_len == '0) ? LEN_WIDTH'(1) : vector_len) : len_q;
    assign last_idx   = cur_len - LEN_WIDTH'(1);
    assign acc_beat   = i_tvalid && tready_q && (state_q == ACCUM);
    assign final_beat = acc_beat && (i_tlast || (cnt_q == last_idx));
    assign early      = acc_beat && i_tlast && (cnt_q != last_idx);
    assign late       = acc_beat && !i_tlast && (cnt_q == last_idx);

    peak_track #(
        .MAG_WIDTH(MAG_WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .SUM_WIDTH(SUM_WIDTH)
    ) u_track (
        .clk_i    (ce_clk),
        .rst_n_i  (ce_rst_n),
        .clear_i  (valid_q && o_ready),
        .load_i   (acc_beat && (cnt_q == '0)),
        .upd_i    (acc_beat),
        .mag_i    (mag),
        .idx_i    (cnt_q),
        .nxt_val_o(nxt_val),
        .nxt_idx_o(nxt_idx),
        .nxt_sum_o(nxt_sum)
    );

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            len_q       <= '0;
            late_pend_q <= 1'b0;
            tready_q    <= 1'b0;
            valid_q     <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    tready_q <= 1'b1;
                    if (acc_beat) begin
                        if (cnt_q == '0) len_q <= cur_len;
                        if (final_beat) begin
                            state_q     <= HOLD;
                            tready_q    <= 1'b0;
                            valid_q     <= 1'b1;
                            cnt_q       <= '0;
                            late_pend_q <= late;
                            if (early) err_early_q <= 1'b1;
                            if (late)  err_late_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    if (o_ready) begin
                        valid_q  <= 1'b0;
                        tready_q <= 1'b1;
                        state_q  <= late_pend_q ? RESYNC : ACCUM;
                    end
                end
                RESYNC: begin
                    // Drop the overrun tail of a vector that never delivered tlast in time.
                    if (i_tvalid && tready_q && i_tlast) state_q <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    always_comb begin
        res_d.bin     = nxt_idx;
        res_d.val     = nxt_val;
        res_d.len_err = early || late;
        res_d.sum     = nxt_sum;
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n)       res_q <= '0;
        else if (final_beat) res_q <= res_d;
    end

    assign i_tready   = tready_q;
    assign o_valid    = valid_q;
    assign o_peak_bin = res_q.bin;
    assign o_peak_val = res_q.val;
    assign o_len_err  = res_q.len_err;
    assign o_sum      = res_q.sum;
    assign err_early  = err_early_q;
    assign err_late   = err_late_q;

endmodule
